inst_mem_pipe: RTL

INST_MEM_PIPE -- requirements
Module: inst_mem_pipe

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/imem_array.sv | 34 +++
 rtl/inst_mem_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory block: NOP encoding and
// the controller state enum.
package riscv_pkg;

    // addi x0, x0, 0 -- returned in place of data for faulting fetches
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } imem_state_e;

    // True when a byte address is word aligned and inside the array.
    function automatic logic addr_ok(input logic [31:0] addr, input int idx_w);
        logic [31:0] upper;
        upper   = addr >> (idx_w + 2);
        addr_ok = (addr[1:0] == 2'b00) && (upper == 32'd0);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port and one byte-enabled write
// port in a single clocked block, read-first on same-word collisions.
module imem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Non-blocking read and write in one block gives read-first ordering.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_pipe.sv
// Pipelined instruction memory: post-reset clear FSM, fetch request/response
// handshake with alignment/range faults, and a byte-enabled loader port.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; a response, once valid, holds inst/fault stable until f_rsp_ready.
module inst_mem_pipe
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int RESET_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_rsp_valid,
    input  logic              f_rsp_ready,
    output logic [31:0]       f_rsp_inst,
    output logic              f_rsp_fault,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [31:0]       w_data,
    input  logic [3:0]        w_be,
    output logic              busy,
    output imem_state_e       dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Controller state
    imem_state_e      state_q;
    logic [IDX_W-1:0] clr_cnt_q;
    logic             busy_q;

    // Response register
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_fault_q, rsp_fault_d;
    logic             rsp_ram_q,   rsp_ram_d;
    logic [31:0]      rsp_inst_q,  rsp_inst_d;

    // Request decode
    logic             req_accept;
    logic             req_in_range;
    logic             req_aligned;
    logic             req_fault;
    logic             w_in_range;
    logic             w_aligned;
    logic [ADDR_W-1:0] req_upper;
    logic [ADDR_W-1:0] w_upper;

    // Array port signals
    logic             arr_rd_en;
    logic [IDX_W-1:0] arr_rd_idx;
    logic [31:0]      arr_rd_data;
    logic             arr_wr_en;
    logic [IDX_W-1:0] arr_wr_idx;
    logic [31:0]      arr_wr_data;
    logic [3:0]       arr_wr_be;

    assign req_upper    = f_req_addr >> (IDX_W + 2);
    assign req_in_range = (req_upper == '0);
    assign req_aligned  = (f_req_addr[1:0] == 2'b00);
    assign req_fault    = !(req_in_range && req_aligned);

    assign w_upper      = w_addr >> (IDX_W + 2);
    assign w_in_range   = (w_upper == '0);
    assign w_aligned    = (w_addr[1:0] == 2'b00);

    assign f_req_ready  = (state_q == ST_RUN) && (!rsp_valid_q || f_rsp_ready);
    assign req_accept   = f_req_valid && f_req_ready;

    // Faulting requests never touch the array, so its output stays put.
    assign arr_rd_en    = req_accept && !req_fault;
    assign arr_rd_idx   = f_req_addr[IDX_W+1:2];

    always_comb begin
        arr_wr_en   = 1'b0;
        arr_wr_idx  = w_addr[IDX_W+1:2];
        arr_wr_data = w_data;
        arr_wr_be   = w_be;
        if (rst) begin
            arr_wr_en = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            arr_wr_en   = 1'b1;
            arr_wr_idx  = clr_cnt_q;
            arr_wr_data = 32'd0;
            arr_wr_be   = 4'hF;
        end else begin
            arr_wr_en = w_en && w_in_range && w_aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (RESET_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            busy_q    <= (RESET_CLEAR != 0);
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b0;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // rsp_ram_q selects the array output; otherwise rsp_inst_q carries NOP or zero.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        rsp_ram_d   = rsp_ram_q;
        rsp_inst_d  = rsp_inst_q;
        if (req_accept) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = req_fault;
            rsp_ram_d   = !req_fault;
            rsp_inst_d  = req_fault ? NOP_INST : 32'd0;
        end else if (f_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_ram_q   <= 1'b0;
            rsp_inst_q  <= 32'd0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_ram_q   <= rsp_ram_d;
            rsp_inst_q  <= rsp_inst_d;
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rd_en   (arr_rd_en),
        .rd_idx  (arr_rd_idx),
        .rd_data (arr_rd_data),
        .wr_en   (arr_wr_en),
        .wr_idx  (arr_wr_idx),
        .wr_data (arr_wr_data),
        .wr_be   (arr_wr_be)
    );

    assign f_rsp_valid = rsp_valid_q;
    assign f_rsp_fault = rsp_fault_q;
    assign f_rsp_inst  = rsp_ram_q ? arr_rd_data : rsp_inst_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule
